// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one AXI-lite-style read per instruction, result handed to
// decode over valid/ready, next fetch launched by a PC from writeback.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [1:0]  OKAY_RESP = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_update_valid,
  input  logic [31:0] pc_update,
  output logic        ifu_send_valid,
  input  logic        ifu_receive_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        fetch_fault,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {BOOT, ADDR, DATA, SEND, WAIT} state_t;

  state_t      state, state_n;
  logic [31:0] pc_n, araddr_n, instruction_n, pending_pc, pending_pc_n, next_pc;
  logic        arvalid_n, rready_n, send_valid_n, fault_n, pending, pending_n, launch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      araddr         <= RESET_PC;
      arvalid        <= 1'b0;
      rready         <= 1'b0;
      ifu_send_valid <= 1'b0;
      instruction    <= '0;
      fetch_fault    <= 1'b0;
      pending        <= 1'b0;
      pending_pc     <= '0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      araddr         <= araddr_n;
      arvalid        <= arvalid_n;
      rready         <= rready_n;
      ifu_send_valid <= send_valid_n;
      instruction    <= instruction_n;
      fetch_fault    <= fault_n;
      pending        <= pending_n;
      pending_pc     <= pending_pc_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    araddr_n      = araddr;
    arvalid_n     = arvalid;
    rready_n      = rready;
    send_valid_n  = ifu_send_valid;
    instruction_n = instruction;
    fault_n       = fetch_fault;
    pending_n     = pending;
    pending_pc_n  = pending_pc;
    launch        = 1'b0;
    next_pc       = pc;

    unique case (state)
      BOOT: begin
        launch  = 1'b1;
        next_pc = pc;
      end
      ADDR: begin
        // A misaligned PC never reaches memory; it is reported as a faulting instruction.
        if (pc[1:0] != 2'b00) begin
          instruction_n = '0;
          fault_n       = 1'b1;
          send_valid_n  = 1'b1;
          state_n       = SEND;
        end else if (arvalid && arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (rvalid && rready) begin
          instruction_n = rdata;
          fault_n       = (rresp != OKAY_RESP);
          rready_n      = 1'b0;
          send_valid_n  = 1'b1;
          state_n       = SEND;
        end
      end
      SEND: begin
        if (ifu_receive_ready) begin
          send_valid_n = 1'b0;
          pending_n    = 1'b0;
          if (pc_update_valid) begin
            launch  = 1'b1;
            next_pc = pc_update;
          end else if (pending) begin
            launch  = 1'b1;
            next_pc = pending_pc;
          end else begin
            state_n = WAIT;
          end
        end else if (pc_update_valid) begin
          pending_n    = 1'b1;
          pending_pc_n = pc_update;
        end
      end
      WAIT: begin
        if (pc_update_valid) begin
          launch  = 1'b1;
          next_pc = pc_update;
        end
      end
      default: state_n = BOOT;
    endcase

    // Every path into ADDR goes through here so pc and araddr always agree.
    if (launch) begin
      state_n   = ADDR;
      pc_n      = next_pc;
      araddr_n  = next_pc;
      arvalid_n = (next_pc[1:0] == 2'b00);
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: behavioural instruction memory, scoreboard of expected
// decode transfers, and directed checks on the read channel.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        pc_update_valid;
  logic [31:0] pc_update;
  logic        ifu_send_valid;
  logic        ifu_receive_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        fetch_fault;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  logic        m_arready, m_rvalid, force_rvalid;
  logic [31:0] m_rdata, force_rdata;
  logic [1:0]  m_rresp;
  int unsigned ar_stall;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  assign arready = m_arready;
  assign rvalid  = m_rvalid | force_rvalid;
  assign rdata   = force_rvalid ? force_rdata : m_rdata;
  assign rresp   = m_rresp;

  ifu_fetch #(.RESET_PC(32'h8000_0000), .OKAY_RESP(2'b00)) dut (
    .clk(clk), .rst(rst),
    .pc_update_valid(pc_update_valid), .pc_update(pc_update),
    .ifu_send_valid(ifu_send_valid), .ifu_receive_ready(ifu_receive_ready),
    .instruction(instruction), .pc(pc), .fetch_fault(fetch_fault),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0513;
    if (a == 32'h8000_0008) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return (a == 32'h8000_0008) ? 2'b10 : 2'b00;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [31:0] i, input logic [31:0] p, input logic f);
    sb.push_back('{instr: i, pc: p, fault: f});
  endtask

  task automatic pulse(input logic [31:0] a);
    pc_update       = a;
    pc_update_valid = 1'b1;
    tick();
    pc_update_valid = 1'b0;
  endtask

  task automatic wait_send();
    for (int unsigned i = 0; i < 30 && !ifu_send_valid; i++) tick();
    if (!ifu_send_valid) check("send_timeout", 32'(ifu_send_valid), 32'd1);
  endtask

  task automatic wait_idle();
    for (int unsigned i = 0; i < 60 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) check("idle_timeout", 32'(sb.size()), 32'd0);
    tick();
  endtask

  // Memory: optional arready stall, read data one cycle after the address handshake.
  initial begin : memory
    logic        ar_fire, r_fire, have_req;
    logic [31:0] req_addr, pend_addr;
    int unsigned waited;
    ar_fire = 1'b0; r_fire = 1'b0; have_req = 1'b0; waited = 0;
    req_addr = '0; pend_addr = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    forever begin
      @(negedge clk);
      if (ar_fire) begin have_req = 1'b1; req_addr = pend_addr; end
      if (r_fire) have_req = 1'b0;
      ar_fire = 1'b0;
      r_fire  = 1'b0;
      if (rst) begin
        have_req = 1'b0; waited = 0; m_arready = 1'b0; m_rvalid = 1'b0;
      end else begin
        m_arready = 1'b0;
        if (arvalid && !have_req) begin
          if (waited < ar_stall) waited++;
          else begin
            m_arready = 1'b1; ar_fire = 1'b1; pend_addr = araddr; waited = 0;
          end
        end
        m_rvalid = have_req;
        if (have_req) begin
          m_rdata = mem_word(req_addr);
          m_rresp = mem_resp(req_addr);
          r_fire  = rready;
        end
      end
    end
  end

  // Monitor: scoreboard pops on decode handshakes, plus hold/no-retraction rules.
  initial begin : monitor
    exp_t        e;
    logic        held, ar_held, h_fault;
    logic [31:0] h_instr, h_pc, h_araddr;
    held = 1'b0; ar_held = 1'b0; h_fault = 1'b0; h_instr = '0; h_pc = '0; h_araddr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        held = 1'b0; ar_held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", 32'(ifu_send_valid), 32'd1);
          check("hold_instr", instruction, h_instr);
          check("hold_pc", pc, h_pc);
          check("hold_fault", 32'(fetch_fault), 32'(h_fault));
        end
        if (ar_held) begin
          check("ar_no_retract", 32'(arvalid), 32'd1);
          check("ar_addr_stable", araddr, h_araddr);
        end
        if (ifu_send_valid && ifu_receive_ready) begin
          if (sb.size() == 0) check("sb_underflow", 32'(ifu_send_valid), 32'd0);
          else begin
            e = sb.pop_front();
            check("sb_instr", instruction, e.instr);
            check("sb_pc", pc, e.pc);
            check("sb_fault", 32'(fetch_fault), 32'(e.fault));
          end
        end
        held    = ifu_send_valid && !ifu_receive_ready;
        h_instr = instruction; h_pc = pc; h_fault = fetch_fault;
        ar_held = arvalid && !arready;
        h_araddr = araddr;
      end
    end
  end

  initial begin : stim
    rst = 1'b1; pc_update_valid = 1'b0; pc_update = '0; ifu_receive_ready = 1'b1;
    force_rvalid = 1'b0; force_rdata = '0; ar_stall = 0;
    repeat (2) tick();
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_send_valid", 32'(ifu_send_valid), 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_araddr", araddr, 32'h8000_0000);

    // First fetch and latency
    push_exp(32'h0000_0513, 32'h8000_0000, 1'b0);
    rst = 1'b0;
    tick();
    check("boot_arvalid", 32'(arvalid), 32'd1);
    check("boot_araddr", araddr, 32'h8000_0000);
    tick();
    check("lat_rready", 32'(rready), 32'd1);
    check("lat_send_early", 32'(ifu_send_valid), 32'd0);
    tick();
    check("lat_send", 32'(ifu_send_valid), 32'd1);
    tick(); tick();
    check("wait_no_ar", 32'(arvalid), 32'd0);
    check("wait_no_send", 32'(ifu_send_valid), 32'd0);

    // Address channel stall
    ar_stall = 3;
    push_exp(mem_word(32'h8000_0004), 32'h8000_0004, 1'b0);
    pulse(32'h8000_0004);
    for (int unsigned i = 0; i < 4; i++) begin
      check("stall_arvalid", 32'(arvalid), 32'd1);
      check("stall_araddr", araddr, 32'h8000_0004);
      if (i < 3) tick();
    end
    ar_stall = 0;
    wait_idle();

    // Decode backpressure
    ifu_receive_ready = 1'b0;
    push_exp(mem_word(32'h8000_000C), 32'h8000_000C, 1'b0);
    pulse(32'h8000_000C);
    wait_send();
    repeat (4) begin
      tick();
      check("bp_valid", 32'(ifu_send_valid), 32'd1);
      check("bp_pc", pc, 32'h8000_000C);
    end
    ifu_receive_ready = 1'b1;
    tick();
    check("bp_single", 32'(ifu_send_valid), 32'd0);
    wait_idle();

    // Error response, then misaligned PC
    push_exp(32'hDEAD_BEEF, 32'h8000_0008, 1'b1);
    pulse(32'h8000_0008);
    wait_idle();
    push_exp(32'h0, 32'h8000_0002, 1'b1);
    pulse(32'h8000_0002);
    check("mis_no_ar", 32'(arvalid), 32'd0);
    tick();
    check("mis_valid", 32'(ifu_send_valid), 32'd1);
    check("mis_fault", 32'(fetch_fault), 32'd1);
    check("mis_instr", instruction, 32'h0);
    wait_idle();

    // Update during SEND is held and used after the handshake
    ifu_receive_ready = 1'b0;
    push_exp(mem_word(32'h8000_0014), 32'h8000_0014, 1'b0);
    pulse(32'h8000_0014);
    wait_send();
    push_exp(mem_word(32'h8000_0010), 32'h8000_0010, 1'b0);
    pulse(32'h8000_0010);
    tick();
    ifu_receive_ready = 1'b1;
    tick();
    check("pend_arvalid", 32'(arvalid), 32'd1);
    check("pend_araddr", araddr, 32'h8000_0010);
    wait_idle();

    // Second update in SEND overwrites the first
    ifu_receive_ready = 1'b0;
    push_exp(mem_word(32'h8000_0018), 32'h8000_0018, 1'b0);
    pulse(32'h8000_0018);
    wait_send();
    push_exp(mem_word(32'h8000_0024), 32'h8000_0024, 1'b0);
    pulse(32'h8000_0020);
    pulse(32'h8000_0024);
    ifu_receive_ready = 1'b1;
    tick();
    check("ovw_arvalid", 32'(arvalid), 32'd1);
    check("ovw_araddr", araddr, 32'h8000_0024);
    wait_idle();

    // Update in the same cycle as the decode handshake
    ifu_receive_ready = 1'b0;
    push_exp(mem_word(32'h8000_0028), 32'h8000_0028, 1'b0);
    pulse(32'h8000_0028);
    wait_send();
    push_exp(mem_word(32'h8000_002C), 32'h8000_002C, 1'b0);
    ifu_receive_ready = 1'b1;
    pulse(32'h8000_002C);
    check("same_arvalid", 32'(arvalid), 32'd1);
    check("same_araddr", araddr, 32'h8000_002C);
    wait_idle();

    // Top of address space
    push_exp(mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b0);
    pulse(32'hFFFF_FFFC);
    wait_idle();

    // Reset while in DATA; a stale response afterwards must be ignored
    pulse(32'h8000_0040);
    tick();
    check("data_rready", 32'(rready), 32'd1);
    rst = 1'b1;
    sb.delete();
    push_exp(32'h0000_0513, 32'h8000_0000, 1'b0);
    tick();
    rst = 1'b0;
    check("rst2_rready", 32'(rready), 32'd0);
    check("rst2_send", 32'(ifu_send_valid), 32'd0);
    force_rdata  = 32'h1234_5678;
    force_rvalid = 1'b1;
    tick();
    check("stale_rready", 32'(rready), 32'd0);
    check("restart_arvalid", 32'(arvalid), 32'd1);
    check("restart_araddr", araddr, 32'h8000_0000);
    force_rvalid = 1'b0;
    wait_idle();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the multi-cycle RV32 core.
- Issues one read per instruction on an AXI-lite-style read channel to instruction memory.
- Presents the fetched {instruction, pc} to the decode stage over a valid/ready handshake.
- Waits for the writeback stage to supply the next PC before fetching again; one instruction is in flight at a time.

Parameters:
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset.
- OKAY_RESP, 2'b00, the only rresp value treated as success.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- pc_update_valid  input  1  writeback has produced the next PC (single-cycle pulse)
- pc_update  input  32  next PC; valid with pc_update_valid
- ifu_send_valid  output  1  instruction/pc/fetch_fault valid toward decode
- ifu_receive_ready  input  1  decode accepts this cycle
- instruction  output  32  fetched instruction word
- pc  output  32  PC of the presented instruction
- fetch_fault  output  1  the presented instruction is invalid (bad response or misaligned PC)
- araddr  output  32  read address
- arvalid  output  1  read address valid
- arready  input  1  memory accepts address
- rdata  input  32  read data
- rresp  input  2  read response
- rvalid  input  1  read data valid
- rready  output  1  IFU accepts read data

Behaviour:
- Interface fixed: one clock, clk; reset rst is synchronous and active-high. Every output is registered.
- Reset values: state=BOOT, pc=RESET_PC, araddr=RESET_PC, arvalid=0, rready=0, ifu_send_valid=0, instruction=0, fetch_fault=0, pending=0.
- BOOT: one cycle, then go to ADDR with arvalid<=1 and araddr<=pc.
- ADDR:
  - araddr=pc; arvalid held high until arvalid&&arready.
  - On handshake: arvalid<=0, rready<=1, go to DATA.
- DATA:
  - On rvalid&&rready: instruction<=rdata, fetch_fault<=(rresp!=OKAY_RESP), rready<=0, ifu_send_valid<=1, go to SEND.
  - rdata is captured even on a fault response.
- SEND:
  - instruction, pc and fetch_fault held stable while ifu_send_valid&&!ifu_receive_ready.
  - On handshake: ifu_send_valid<=0.
  - Next state: if pending, go to ADDR (pc<=pending_pc, arvalid<=1, pending<=0); otherwise go to WAIT.
- WAIT: on pc_update_valid, pc<=pc_update, araddr<=pc_update, arvalid<=1, go to ADDR.
- pc_update_valid outside WAIT:
  - In SEND: captured into pending/pending_pc, which are the only holding registers. A second pulse overwrites them.
  - Same cycle as the SEND handshake: the new PC is used directly; ADDR is entered next cycle.
  - In BOOT, ADDR or DATA: ignored (upstream protocol violation; verification asserts it never occurs).
- Misaligned PC (pc[1:0]!=0) on entry to ADDR:
  - No memory request: arvalid stays 0.
  - Next cycle: instruction<=0, fetch_fault<=1, ifu_send_valid<=1, go to SEND.
- Latency: with arready and rvalid each asserted in the first possible cycle, ifu_send_valid rises 2 cycles after ADDR is entered.
- Once arvalid is high, it never drops before arready (no retraction).
- rready is high only in DATA.
- Reset mid-operation:
  - Any state returns to BOOT and all handshakes are dropped.
  - A response arriving after reset is ignored, because rready=0 until the next DATA.
  - Memory shares rst.
- Wrap-around: pc_update=32'hFFFF_FFFC is fetched normally; there is no PC arithmetic inside the block.

Test Plan:
- Reset, arready=1, rvalid one cycle after AR with rdata=32'h0000_0513, rresp=0, ready=1 -> araddr=32'h8000_0000; send_valid with instruction=32'h0000_0513, pc=32'h8000_0000, fault=0; then WAIT with no arvalid.
- In WAIT, pulse pc_update=32'h8000_0004 -> next cycle arvalid=1, araddr=32'h8000_0004; arready held low 3 cycles -> arvalid and araddr stable throughout.
- Decode backpressure: ifu_receive_ready=0 for 4 cycles -> instruction, pc, fault unchanged, send_valid held high; single transfer when ready rises.
- rresp=2'b10, rdata=32'hDEAD_BEEF -> instruction=32'hDEAD_BEEF with fetch_fault=1; pc_update=32'h8000_0002 -> no arvalid, instruction=0 with fetch_fault=1 next cycle.
- pc_update_valid (32'h8000_0010) pulsed in SEND while ready=0 -> after the handshake, ADDR with araddr=32'h8000_0010 and no stall in WAIT.
- Assert rst while in DATA, then drive rvalid=1 -> rready=0, response ignored; fetch restarts at 32'h8000_0000.
